// File: rtl/sp_ram_loader_if.sv
// Byte-stream, read-request and RAM-port bundle for sp_ram_loader.
// The loader uses the slave modport and the environment uses the master modport.
interface sp_ram_loader_if #(
  parameter int unsigned ADDR_W = 15
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [7:0]        rd_data;
  logic              ram_ce;
  logic              ram_wre;
  logic              ram_oce;
  logic [ADDR_W-1:0] ram_ad;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;

  modport master (
    output rx_data, rx_valid, rd_req, rd_addr, ram_dout,
    input  rx_ready, rd_valid, rd_data, ram_ce, ram_wre, ram_oce, ram_ad, ram_din
  );

  modport slave (
    input  rx_data, rx_valid, rd_req, rd_addr, ram_dout,
    output rx_ready, rd_valid, rd_data, ram_ce, ram_wre, ram_oce, ram_ad, ram_din
  );
endinterface

// File: rtl/sp_ram_loader.sv
// Streams a header-prefixed image into a single-port RAM with a running checksum,
// and serves single-byte reads from the emulator core when no load is active.
module sp_ram_loader #(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned HDR_BYTES = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_load_len,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [7:0]        o_checksum,
  sp_ram_loader_if.slave    bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned HDR_W = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
  localparam logic [CNT_W-1:0] LEN_MAX  = CNT_W'(1) << ADDR_W;
  localparam logic [HDR_W-1:0] HDR_LAST = HDR_W'(HDR_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_LOAD, S_DONE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_wptr;
  logic [HDR_W-1:0]  r_hdr;
  logic [7:0]        r_checksum;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic              r_rd_valid;

  logic              w_rx_fire;
  logic              w_len_ok;
  logic              w_serve;
  logic              w_last;

  assign w_len_ok   = (i_load_len != '0) && (i_load_len <= LEN_MAX);
  assign w_serve    = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_rx_fire  = bus.rx_valid && bus.rx_ready;
  assign w_last     = ((r_cnt + CNT_W'(1)) == r_len);

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_error       = r_error;
  assign o_checksum    = r_checksum;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = bus.ram_dout;
  assign bus.ram_oce   = 1'b1;

  // RAM port mux: load writes take the port while busy, reads only when idle/done.
  always_comb begin
    bus.rx_ready = 1'b0;
    bus.ram_ce   = 1'b0;
    bus.ram_wre  = 1'b0;
    bus.ram_ad   = '0;
    bus.ram_din  = '0;
    if (!i_reset) begin
      bus.rx_ready = (r_state == S_HDR) || (r_state == S_LOAD);
      if ((r_state == S_LOAD) && bus.rx_valid) begin
        bus.ram_ce  = 1'b1;
        bus.ram_wre = 1'b1;
        bus.ram_ad  = r_wptr;
        bus.ram_din = bus.rx_data;
      end else if (w_serve && bus.rd_req) begin
        bus.ram_ce = 1'b1;
        bus.ram_ad = bus.rd_addr;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_cnt      <= '0;
      r_wptr     <= '0;
      r_hdr      <= '0;
      r_checksum <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_req && w_serve;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_checksum <= '0;
            if (w_len_ok) begin
              r_len   <= i_load_len;
              r_cnt   <= '0;
              r_wptr  <= '0;
              r_hdr   <= '0;
              r_done  <= 1'b0;
              r_error <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= (HDR_BYTES == 0) ? S_LOAD : S_HDR;
            end else begin
              r_done  <= 1'b1;
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end
          end
        end
        S_HDR: begin
          if (w_rx_fire) begin
            r_hdr <= r_hdr + HDR_W'(1);
            if (r_hdr == HDR_LAST) r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_rx_fire) begin
            r_wptr     <= r_wptr + ADDR_W'(1);
            r_cnt      <= r_cnt + CNT_W'(1);
            r_checksum <= r_checksum + bus.rx_data;
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_ram_loader.sv
// Randomized scoreboard bench for sp_ram_loader with a behavioural RAM and reference image.
module tb_sp_ram_loader;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned HDR    = 16;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic              busy, done, error;
  logic [7:0]        checksum;

  sp_ram_loader_if #(.ADDR_W(ADDR_W)) bus ();

  sp_ram_loader #(.ADDR_W(ADDR_W), .HDR_BYTES(HDR)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_load_len (load_len),
    .o_busy     (busy),
    .o_done     (done),
    .o_error    (error),
    .o_checksum (checksum),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM, one-cycle read latency.
  logic [7:0] ram [0:DEPTH-1];
  logic [7:0] ram_q = 8'h00;
  always @(posedge clk) begin
    if (bus.ram_ce) begin
      if (bus.ram_wre) ram[bus.ram_ad] <= bus.ram_din;
      else             ram_q <= ram[bus.ram_ad];
    end
  end
  assign bus.ram_dout = ram_q;

  // Reference image of what the RAM must contain, plus scoreboards.
  logic [7:0]  exp_mem [0:DEPTH-1];
  logic [7:0]  exp_sum;
  logic [22:0] wq [$];
  logic [7:0]  rq [$];
  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: pops expected writes/read data whenever the DUT presents them.
  always @(negedge clk) begin
    logic [22:0] e;
    logic [7:0]  d;
    if (bus.ram_ce === 1'b1 && bus.ram_wre === 1'b1) begin
      if (wq.size() == 0) chk("unexpected_write", {9'd0, bus.ram_ad, bus.ram_din}, 32'hFFFF_FFFF);
      else begin
        e = wq.pop_front();
        chk("write", {9'd0, bus.ram_ad, bus.ram_din}, {9'd0, e});
      end
    end
    if (bus.ram_ce === 1'b1 && bus.ram_wre === 1'b0) begin
      chk("read_while_busy", busy, 0);
      chk("read_addr", bus.ram_ad, bus.rd_addr);
    end
    if (bus.rd_valid === 1'b1) begin
      if (rq.size() == 0) chk("unexpected_rd_valid", bus.rd_data, 32'hFFFF_FFFF);
      else begin
        d = rq.pop_front();
        chk("rd_data", bus.rd_data, d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int len);
    start = 1'b1;
    load_len = (ADDR_W+1)'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit payload, input int idx,
                           input bit gaps, input bit noise);
    int t;
    if (gaps && $urandom_range(0, 3) == 0) begin
      bus.rx_valid = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    if (payload) begin
      wq.push_back({ADDR_W'(idx), b});
      exp_mem[ADDR_W'(idx)] = b;
      exp_sum = exp_sum + b;
    end
    if (noise) begin
      bus.rd_req  = ($urandom_range(0, 1) == 1);
      bus.rd_addr = ADDR_W'($urandom);
      start       = ($urandom_range(0, 7) == 0);
      load_len    = (ADDR_W+1)'($urandom_range(0, 40000));
    end
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.rx_ready) break;
      t++;
      if (t > 50) begin
        chk("rx_ready_timeout", 0, 1);
        break;
      end
    end
    tick();
    bus.rx_valid = 1'b0;
    bus.rd_req   = 1'b0;
    start        = 1'b0;
  endtask

  task automatic run_load(input int len, input int mode, input bit gaps, input bit noise);
    logic [7:0] b;
    pulse_start(len);
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_error", error, 0);
    chk("start_rx_ready", bus.rx_ready, 1);
    chk("start_checksum", checksum, 0);
    exp_sum = 8'h00;
    for (int h = 0; h < int'(HDR); h++) send_byte(8'($urandom), 1'b0, 0, gaps, noise);
    for (int i = 0; i < len; i++) begin
      case (mode)
        1:       b = 8'(i);
        2:       b = 8'(8'h11 * (i + 1));
        default: b = 8'($urandom);
      endcase
      send_byte(b, 1'b1, i, gaps, noise);
    end
    chk("done_rise", done, 1);
    chk("done_busy", busy, 0);
    chk("done_rx_ready", bus.rx_ready, 0);
    chk("done_error", error, 0);
    chk("checksum", checksum, exp_sum);
  endtask

  task automatic do_read(input int addr);
    bus.rd_req  = 1'b1;
    bus.rd_addr = ADDR_W'(addr);
    rq.push_back(exp_mem[ADDR_W'(addr)]);
    tick();
    bus.rd_req  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, bus.rx_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_checksum"}, checksum, 0);
    chk({tag, "_rd_valid"}, bus.rd_valid, 0);
    chk({tag, "_ram_ce"}, bus.ram_ce, 0);
    chk({tag, "_ram_wre"}, bus.ram_wre, 0);
    chk({tag, "_ram_ad"}, bus.ram_ad, 0);
    chk({tag, "_ram_din"}, bus.ram_din, 0);
    chk({tag, "_ram_oce"}, bus.ram_oce, 1);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;
    exp_sum      = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_vals("por");

    // Directed load: 16 header bytes then 11,22,33,44.
    run_load(4, 2, 1'b0, 1'b0);
    chk("plan_checksum", checksum, 8'hAA);
    for (int a = 0; a < 4; a++) do_read(a);
    repeat (2) tick();
    for (int k = 0; k < 6; k++) do_read($urandom_range(0, 3));

    // Random load with read requests and start pulses injected while busy.
    run_load(50, 0, 1'b1, 1'b1);
    repeat (2) tick();
    for (int k = 0; k < 8; k++) do_read($urandom_range(0, 49));
    repeat (2) tick();

    // Illegal lengths, then a legal start clears the error.
    pulse_start(0);
    chk("ill0_done", done, 1);
    chk("ill0_error", error, 1);
    chk("ill0_busy", busy, 0);
    chk("ill0_checksum", checksum, 0);
    repeat (2) tick();
    pulse_start(DEPTH + 1);
    chk("ill1_done", done, 1);
    chk("ill1_error", error, 1);
    chk("ill1_rx_ready", bus.rx_ready, 0);
    repeat (2) tick();
    run_load(3, 0, 1'b1, 1'b0);

    // Full-capacity load, bytes equal to address low byte.
    run_load(DEPTH, 1, 1'b1, 1'b0);
    chk("full_checksum", checksum, 8'h00);
    do_read(0);
    do_read(DEPTH - 1);
    do_read(16'h0100);
    repeat (2) tick();

    // Reset asserted mid-load with a byte pending.
    pulse_start(10);
    exp_sum = 8'h00;
    for (int h = 0; h < int'(HDR); h++) send_byte(8'($urandom), 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1, i, 1'b0, 1'b0);
    bus.rx_data  = 8'h55;
    bus.rx_valid = 1'b1;
    rst = 1'b1;
    tick();
    check_reset_vals("rst1");
    tick();
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    check_reset_vals("rst2");
    for (int a = 0; a < 4; a++) do_read(a);
    repeat (3) tick();

    chk("write_queue_drained", wq.size(), 0);
    chk("read_queue_drained", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
